// File: rtl/tmr_vote_monitor_if.sv
// Replica inputs, voted output and fault/status bundle for tmr_vote_monitor.
// master = system side driving replicas, slave = the monitor.
interface tmr_vote_monitor_if #(
    parameter int DATA_W = 144,
    parameter int CNT_W  = 8
);
    logic              valid_a;
    logic              valid_b;
    logic              valid_c;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] data_c;
    logic              clear_fault;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              mismatch;
    logic              uncorrectable;
    logic              fault_a;
    logic              fault_b;
    logic              fault_c;
    logic [CNT_W-1:0]  err_cnt_a;
    logic [CNT_W-1:0]  err_cnt_b;
    logic [CNT_W-1:0]  err_cnt_c;
    logic [1:0]        mode;

    modport master (
        output valid_a, valid_b, valid_c, data_a, data_b, data_c, clear_fault,
        input  out_valid, out_data, mismatch, uncorrectable,
               fault_a, fault_b, fault_c, err_cnt_a, err_cnt_b, err_cnt_c, mode
    );

    modport slave (
        input  valid_a, valid_b, valid_c, data_a, data_b, data_c, clear_fault,
        output out_valid, out_data, mismatch, uncorrectable,
               fault_a, fault_b, fault_c, err_cnt_a, err_cnt_b, err_cnt_c, mode
    );
endinterface

// File: rtl/tmr_vote_monitor.sv
// Registered bitwise-majority voter over three replicas with persistent-fault
// exclusion (TMR -> DMR -> FAIL), per-replica error counters and fault status.
module tmr_vote_monitor #(
    parameter int DATA_W    = 144,
    parameter int ERR_LIMIT = 4,
    parameter int CNT_W     = 8
) (
    input logic             clk,
    input logic             reset,
    tmr_vote_monitor_if.slave bus
);
    localparam logic [1:0] MODE_TMR  = 2'b00;
    localparam logic [1:0] MODE_DMR  = 2'b01;
    localparam logic [1:0] MODE_FAIL = 2'b10;

    localparam int TW = DATA_W + 1;
    localparam int CW = $clog2(ERR_LIMIT + 1);
    localparam logic [CW-1:0] LIM_M1 = CW'(ERR_LIMIT - 1);

    logic [TW-1:0]     t [3];
    logic [TW-1:0]     maj, p0, p1;
    logic [2:0]        dis, hit;
    logic [1:0]        nhit;
    logic              pair_dif;

    logic [1:0]        mode_q, mode_n;
    logic [2:0]        fault_q, fault_n;
    logic              unc_q, unc_n, mis_q, mis_n, ov_q, ov_n;
    logic [DATA_W-1:0] od_q, od_n;
    logic [CNT_W-1:0]  err_q [3];
    logic [CNT_W-1:0]  err_n [3];
    logic [CW-1:0]     cons_q [3];
    logic [CW-1:0]     cons_n [3];
    logic [CW-1:0]     pair_q, pair_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] e);
        return (e == '1) ? e : e + 1'b1;
    endfunction

    assign t[0] = {bus.valid_a, bus.data_a};
    assign t[1] = {bus.valid_b, bus.data_b};
    assign t[2] = {bus.valid_c, bus.data_c};
    assign maj  = (t[0] & t[1]) | (t[0] & t[2]) | (t[1] & t[2]);
    assign dis  = {t[2] != maj, t[1] != maj, t[0] != maj};

    // Surviving pair is chosen from the fault flags; with no fault it is A/B.
    always_comb begin
        if (fault_q[0]) begin
            p0 = t[1];
            p1 = t[2];
        end else if (fault_q[1]) begin
            p0 = t[0];
            p1 = t[2];
        end else begin
            p0 = t[0];
            p1 = t[1];
        end
    end
    assign pair_dif = (p0 != p1);

    always_comb begin
        mode_n  = mode_q;
        fault_n = fault_q;
        unc_n   = unc_q;
        mis_n   = 1'b0;
        ov_n    = 1'b0;
        od_n    = od_q;
        err_n   = err_q;
        cons_n  = cons_q;
        pair_n  = pair_q;
        hit     = '0;
        nhit    = '0;
        case (mode_q)
            MODE_TMR: begin
                ov_n  = maj[DATA_W];
                od_n  = maj[DATA_W-1:0];
                mis_n = |dis;
                unc_n = 1'b0;
                for (int unsigned i = 0; i < 3; i++) begin
                    if (dis[i]) begin
                        err_n[i]  = sat_inc(err_q[i]);
                        cons_n[i] = cons_q[i] + 1'b1;
                        hit[i]    = (cons_q[i] == LIM_M1);
                    end else begin
                        cons_n[i] = '0;
                    end
                end
                nhit = 2'(hit[0]) + 2'(hit[1]) + 2'(hit[2]);
                if (nhit == 2'd1) begin
                    mode_n  = MODE_DMR;
                    fault_n = hit;
                end else if (nhit >= 2'd2) begin
                    mode_n  = MODE_FAIL;
                    fault_n = hit;
                    unc_n   = 1'b1;
                end
            end
            MODE_DMR: begin
                mis_n = pair_dif;
                if (pair_dif) begin
                    unc_n  = 1'b1;
                    pair_n = pair_q + 1'b1;
                    for (int unsigned i = 0; i < 3; i++)
                        if (!fault_q[i]) err_n[i] = sat_inc(err_q[i]);
                    if (pair_q == LIM_M1) mode_n = MODE_FAIL;
                end else begin
                    ov_n   = p0[DATA_W];
                    od_n   = p0[DATA_W-1:0];
                    unc_n  = 1'b0;
                    pair_n = '0;
                end
            end
            MODE_FAIL: begin
                mis_n = pair_dif;
                unc_n = 1'b1;
            end
            default: mode_n = MODE_TMR;
        endcase
        // Data outputs and err counts keep the old-mode result; only state is reset.
        if (bus.clear_fault) begin
            mode_n  = MODE_TMR;
            fault_n = '0;
            unc_n   = 1'b0;
            pair_n  = '0;
            for (int unsigned i = 0; i < 3; i++) cons_n[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= MODE_TMR;
            fault_q <= '0;
            unc_q   <= 1'b0;
            mis_q   <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            pair_q  <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                err_q[i]  <= '0;
                cons_q[i] <= '0;
            end
        end else begin
            mode_q  <= mode_n;
            fault_q <= fault_n;
            unc_q   <= unc_n;
            mis_q   <= mis_n;
            ov_q    <= ov_n;
            od_q    <= od_n;
            pair_q  <= pair_n;
            for (int unsigned i = 0; i < 3; i++) begin
                err_q[i]  <= err_n[i];
                cons_q[i] <= cons_n[i];
            end
        end
    end

    assign bus.out_valid     = ov_q;
    assign bus.out_data      = od_q;
    assign bus.mismatch      = mis_q;
    assign bus.uncorrectable = unc_q;
    assign bus.fault_a       = fault_q[0];
    assign bus.fault_b       = fault_q[1];
    assign bus.fault_c       = fault_q[2];
    assign bus.err_cnt_a     = err_q[0];
    assign bus.err_cnt_b     = err_q[1];
    assign bus.err_cnt_c     = err_q[2];
    assign bus.mode          = mode_q;
endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Directed bench for tmr_vote_monitor: voting, fault exclusion, DMR/FAIL,
// clear_fault, reset and counter saturation (second small instance).
module tb_tmr_vote_monitor;
    localparam int DW = 144;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tmr_vote_monitor_if #(.DATA_W(DW), .CNT_W(8)) b1 ();
    tmr_vote_monitor_if #(.DATA_W(8),  .CNT_W(3)) b2 ();

    tmr_vote_monitor #(.DATA_W(DW), .ERR_LIMIT(4), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .bus(b1)
    );
    tmr_vote_monitor #(.DATA_W(8), .ERR_LIMIT(16), .CNT_W(3)) dut2 (
        .clk(clk), .reset(reset), .bus(b2)
    );

    int n_vec  = 0;
    int n_miss = 0;
    logic [DW-1:0] A5, X5A;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic va, input logic vb, input logic vc,
                         input logic [DW-1:0] da, input logic [DW-1:0] db, input logic [DW-1:0] dc);
        b1.valid_a = va; b1.valid_b = vb; b1.valid_c = vc;
        b1.data_a  = da; b1.data_b  = db; b1.data_c  = dc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        A5  = {18{8'hA5}};
        X5A = {18{8'h5A}};
        reset = 1'b1;
        b1.clear_fault = 1'b0;
        drive(1, 1, 1, A5, A5, A5);
        b2.valid_a = 0; b2.valid_b = 0; b2.valid_c = 0;
        b2.data_a = '0; b2.data_b = '0; b2.data_c = '0; b2.clear_fault = 1'b0;
        tick; tick;
        chk("rst_ov", b1.out_valid, 0);
        chk("rst_od", b1.out_data, 0);
        chk("rst_mode", b1.mode, 0);
        chk("rst_flags", {b1.mismatch, b1.uncorrectable, b1.fault_a, b1.fault_b, b1.fault_c}, 0);
        chk("rst_err", {b1.err_cnt_a, b1.err_cnt_b, b1.err_cnt_c}, 0);
        reset = 1'b0;

        // all replicas agree
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("agree_od", b1.out_data, A5);
            chk("agree_ov", b1.out_valid, 1);
            chk("agree_mis", b1.mismatch, 0);
        end
        chk("agree_mode", b1.mode, 0);
        chk("agree_err", {b1.err_cnt_a, b1.err_cnt_b, b1.err_cnt_c}, 0);

        // C: 3 mismatches, 1 agree, 3 mismatches -> no exclusion
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 1, A5, A5, (i == 3) ? A5 : X5A);
            tick;
            chk("c313_mis", b1.mismatch, (i == 3) ? 1'b0 : 1'b1);
            chk("c313_od", b1.out_data, A5);
        end
        chk("c313_mode", b1.mode, 0);
        chk("c313_fault", {b1.fault_a, b1.fault_b, b1.fault_c}, 0);
        chk("c313_err", {b1.err_cnt_a, b1.err_cnt_b, b1.err_cnt_c}, {8'd0, 8'd0, 8'd6});
        drive(1, 1, 1, A5, A5, A5);
        tick;
        chk("c313_hold", b1.err_cnt_c, 6);

        reset = 1'b1; tick; reset = 1'b0;
        chk("rst2_err", b1.err_cnt_c, 0);

        // C stuck at valid=0/data=0 -> excluded on 4th output
        drive(1, 1, 0, A5, A5, '0);
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk("cstk_mis", b1.mismatch, 1);
            chk("cstk_od", b1.out_data, A5);
            chk("cstk_ov", b1.out_valid, 1);
            chk("cstk_errc", b1.err_cnt_c, k);
            chk("cstk_mode", b1.mode, (k == 4) ? 2'd1 : 2'd0);
            chk("cstk_fault", {b1.fault_a, b1.fault_b, b1.fault_c}, (k == 4) ? 3'b001 : 3'b000);
        end
        drive(1, 1, 0, X5A, X5A, '1);
        tick;
        chk("dmr_ignc_err", b1.err_cnt_c, 4);
        chk("dmr_ignc_mis", b1.mismatch, 0);
        chk("dmr_ignc_od", {b1.out_valid, b1.out_data}, {1'b1, X5A});
        chk("dmr_ignc_mode", b1.mode, 1);

        // DMR: single pair difference
        drive(1, 1, 1, A5, A5 ^ {{(DW-1){1'b0}}, 1'b1}, '0);
        tick;
        chk("dmr_dif_ov", b1.out_valid, 0);
        chk("dmr_dif_od", b1.out_data, X5A);
        chk("dmr_dif_flags", {b1.mismatch, b1.uncorrectable}, 2'b11);
        chk("dmr_dif_err", {b1.err_cnt_a, b1.err_cnt_b, b1.err_cnt_c}, {8'd1, 8'd1, 8'd4});
        drive(1, 1, 0, A5, A5, '0);
        tick;
        chk("dmr_agr_od", {b1.out_valid, b1.out_data}, {1'b1, A5});
        chk("dmr_agr_flags", {b1.mismatch, b1.uncorrectable}, 2'b00);

        // DMR: 4 consecutive differences -> FAIL
        drive(1, 0, 1, X5A, X5A, X5A);
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk("dmr4_ov", b1.out_valid, 0);
            chk("dmr4_od", b1.out_data, A5);
            chk("dmr4_unc", b1.uncorrectable, 1);
            chk("dmr4_mode", b1.mode, (k == 4) ? 2'd2 : 2'd1);
        end
        chk("dmr4_err", {b1.err_cnt_a, b1.err_cnt_b, b1.err_cnt_c}, {8'd5, 8'd5, 8'd4});
        drive(1, 1, 1, X5A, X5A, X5A);
        tick;
        chk("fail_mode", b1.mode, 2);
        chk("fail_out", {b1.out_valid, b1.out_data}, {1'b0, A5});
        chk("fail_flags", {b1.mismatch, b1.uncorrectable}, 2'b01);
        chk("fail_err", {b1.err_cnt_a, b1.err_cnt_b, b1.err_cnt_c}, {8'd5, 8'd5, 8'd4});

        // clear_fault from FAIL
        b1.clear_fault = 1'b1;
        tick;
        b1.clear_fault = 1'b0;
        chk("clr_mode", b1.mode, 0);
        chk("clr_fault", {b1.fault_a, b1.fault_b, b1.fault_c}, 0);
        chk("clr_unc", b1.uncorrectable, 0);
        chk("clr_oldout", b1.out_valid, 0);
        chk("clr_err", {b1.err_cnt_a, b1.err_cnt_b, b1.err_cnt_c}, {8'd5, 8'd5, 8'd4});
        tick;
        chk("clr_tmr_out", {b1.out_valid, b1.out_data}, {1'b1, X5A});

        // reset in the middle of DMR
        drive(1, 1, 1, A5, A5, X5A);
        tick; tick; tick; tick;
        chk("dmr2_mode", b1.mode, 1);
        chk("dmr2_errc", b1.err_cnt_c, 8);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rstd_out", {b1.out_valid, b1.out_data}, 0);
        chk("rstd_mode", b1.mode, 0);
        chk("rstd_flags", {b1.mismatch, b1.uncorrectable, b1.fault_a, b1.fault_b, b1.fault_c}, 0);
        chk("rstd_err", {b1.err_cnt_a, b1.err_cnt_b, b1.err_cnt_c}, 0);

        // clear_fault coincident with the limit-reaching mismatch
        tick; tick; tick;
        b1.clear_fault = 1'b1;
        tick;
        b1.clear_fault = 1'b0;
        chk("clrc_mode", b1.mode, 0);
        chk("clrc_fault", b1.fault_c, 0);
        chk("clrc_errc", b1.err_cnt_c, 4);
        chk("clrc_mis", b1.mismatch, 1);
        tick;
        chk("clrc2_mode", b1.mode, 0);
        chk("clrc2_errc", b1.err_cnt_c, 5);

        // CNT_W=3, ERR_LIMIT=16: counter saturation
        b2.valid_c = 1'b1;
        b2.data_c  = 8'h3C;
        for (int i = 1; i <= 10; i++) begin
            tick;
            chk("sat_errc", b2.err_cnt_c, (i < 7) ? i : 7);
        end
        chk("sat_mode", b2.mode, 0);
        chk("sat_fault", b2.fault_c, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
